// File: rtl/qpsk_modulator.sv
// -----------------------------------------------------------------------------
// qpsk_modulator
//
// Purpose:
//   QPSK passband modulator.
//
//   - Symbols arrive on a valid/ready handshake and go into a one-deep buffer.
//   - Each symbol is held for SYM_CYCLES clocks.
//   - Each clock the block forms s = I*cos - Q*sin, with I,Q in {+1,-1}.
//   - The sum goes through a 2-stage pipeline to mod_out.
//   - Back-to-back symbols play gaplessly when the buffer is loaded in time.
//
// Parameters:
//   SYM_CYCLES  clocks per symbol (2 .. 2**CNT_W)
//   CNT_W       width of the symbol-cycle counter
//
// Optional build macro:
//   MOD_SAT_EN  when defined, the output is clamped to [-255,+255] so it fits
//               a symmetric 9-bit DAC. When undefined, the full range
//               -256..+256 passes through unmodified.
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   reset_n    in   asynchronous active-low reset
//   enable     in   1 = may load new symbols; 0 = finish current symbol, idle
//   sym_data   in   [1] I sign, [0] Q sign (0 = +1, 1 = -1)
//   sym_valid  in   sym_data valid
//   sym_ready  out  symbol can be accepted this cycle
//   sin, cos   in   signed 8-bit carrier samples
//   mod_out    out  signed 10-bit modulated sample
//   mod_valid  out  mod_out carries a symbol sample
//   sym_start  out  mod_out is the first sample of a symbol
//   underflow  out  1-cycle pulse: symbol ended with no successor, enable=1
// -----------------------------------------------------------------------------
module qpsk_modulator #(
  parameter int SYM_CYCLES = 256,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] sym_data,
  input  logic       sym_valid,
  output logic       sym_ready,
  input  logic [7:0] sin,
  input  logic [7:0] cos,
  output logic [9:0] mod_out,
  output logic       mod_valid,
  output logic       sym_start,
  output logic       underflow
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             buf_full_q;
  logic [1:0]       buf_sym_q;
  logic [1:0]       cur_sym_q;
  logic             underflow_q;

  // Pipeline registers
  logic [8:0]       it_q, qt_q;
  logic             act1_q, first1_q;
  logic [9:0]       mod_out_q;
  logic             mod_valid_q, sym_start_q;

  // Combinational next values for the pipeline
  logic [8:0]       cos_ext_d, sin_ext_d;
  logic [8:0]       it_d, qt_d;
  logic [9:0]       sum_d, out_d;

  // The buffer can only take a symbol when empty, so an accept never
  // coincides with a load out of the buffer.
  assign sym_ready = enable && !buf_full_q;

  // ---------------------------------------------------------------------------
  // Symbol buffer and sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      buf_full_q  <= 1'b0;
      buf_sym_q   <= '0;
      cur_sym_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= 1'b0;

      if (sym_valid && sym_ready) begin
        buf_sym_q  <= sym_data;
        buf_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (buf_full_q && enable) begin
            cur_sym_q  <= buf_sym_q;
            buf_full_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (buf_full_q && enable) begin
              // Reload at the terminal count so the next symbol has no gap.
              cur_sym_q  <= buf_sym_q;
              buf_full_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              // Starvation is flagged only while the source is supposed to
              // be feeding us. A deliberate stop (enable=0) is not flagged.
              underflow_q <= enable;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: signed terms.
  // Each term is sign-extended to 9 bits before negation, so -(-128) = +128.
  // ---------------------------------------------------------------------------
  always_comb begin
    cos_ext_d = {cos[7], cos};
    sin_ext_d = {sin[7], sin};
    it_d      = cur_sym_q[1] ? -cos_ext_d : cos_ext_d;
    // Subtracting Q*sin: Q=+1 contributes -sin, Q=-1 contributes +sin.
    qt_d      = cur_sym_q[0] ? sin_ext_d : -sin_ext_d;
  end

  // ---------------------------------------------------------------------------
  // Stage 2: sum, optional clamp, gate by activity.
  // ---------------------------------------------------------------------------
  always_comb begin
    sum_d = {it_q[8], it_q} + {qt_q[8], qt_q};
    out_d = sum_d;
`ifdef MOD_SAT_EN
    // The sum is bounded to -256..+256, so only the two extremes need clamping.
    if (sum_d == 10'h100) begin
      out_d = 10'h0FF;    // +256 -> +255
    end else if (sum_d == 10'h300) begin
      out_d = 10'h301;    // -256 -> -255
    end
`endif
    if (!act1_q) begin
      out_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      it_q        <= '0;
      qt_q        <= '0;
      act1_q      <= 1'b0;
      first1_q    <= 1'b0;
      mod_out_q   <= '0;
      mod_valid_q <= 1'b0;
      sym_start_q <= 1'b0;
    end else begin
      it_q        <= it_d;
      qt_q        <= qt_d;
      act1_q      <= (state_q == RUN);
      first1_q    <= (state_q == RUN) && (cnt_q == '0);
      mod_out_q   <= out_d;
      mod_valid_q <= act1_q;
      sym_start_q <= first1_q;
    end
  end

  assign mod_out   = mod_out_q;
  assign mod_valid = mod_valid_q;
  assign sym_start = sym_start_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_qpsk_modulator.sv
// -----------------------------------------------------------------------------
// tb_qpsk_modulator
//
// Directed, table-driven bench for qpsk_modulator with SYM_CYCLES=4.
// Inputs are driven and outputs sampled on the falling clock edge.
//
// Expected values follow s = I*cos - Q*sin, where sym[1]=1 means I=-1 and
// sym[0]=1 means Q=-1. For cos=sin=-128:
//   sym 10: I=-1, Q=+1 -> +128 + 128 = +256
//   sym 01: I=+1, Q=-1 -> -128 - 128 = -256
// -----------------------------------------------------------------------------
module tb_qpsk_modulator;

  localparam int SYMC = 4;

`ifdef MOD_SAT_EN
  localparam int P256 = 255;
  localparam int N256 = -255;
`else
  localparam int P256 = 256;
  localparam int N256 = -256;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [1:0] sym_data;
  logic       sym_valid;
  logic       sym_ready;
  logic [7:0] sin, cos;
  logic [9:0] mod_out;
  logic       mod_valid, sym_start, underflow;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  qpsk_modulator #(.SYM_CYCLES(SYMC), .CNT_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .sym_data  (sym_data),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sin       (sin),
    .cos       (cos),
    .mod_out   (mod_out),
    .mod_valid (mod_valid),
    .sym_start (sym_start),
    .underflow (underflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  typedef struct {
    logic [1:0] sym;
    int         c;
    int         s;
    int         exp;
  } vec_t;

  vec_t vecs[8];

  // Single symbol from idle. Expect 4 samples starting 4 negedges after the
  // drive point (accept, load, stage 1, stage 2), then one underflow pulse.
  task automatic run_symbol(input logic [1:0] sym, input int c, input int s,
                            input int exp, input string tag);
    int nvalid    = 0;
    int nstart    = 0;
    int nuf       = 0;
    int first_idx = -1;
    int start_idx = -1;
    @(negedge clk);
    cos       = 8'(c);
    sin       = 8'(s);
    sym_data  = sym;
    sym_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) sym_valid = 1'b0;
      if (mod_valid) begin
        if (first_idx < 0) first_idx = i;
        nvalid++;
        chk({tag, " mod_out"}, int'($signed(mod_out)), exp);
      end
      if (sym_start) begin
        nstart++;
        start_idx = i;
      end
      if (underflow) nuf++;
    end
    chk({tag, " first_valid_idx"}, first_idx, 4);
    chk({tag, " n_valid"}, nvalid, SYMC);
    chk({tag, " n_sym_start"}, nstart, 1);
    chk({tag, " sym_start_idx"}, start_idx, 4);
    chk({tag, " n_underflow"}, nuf, 1);
  endtask

  // Four symbols with sym_valid held high: 16 gapless samples.
  task automatic back_to_back();
    logic [1:0] syms[4];
    int         exps[4];
    int         k = 0;
    logic       acc;
    int         n = 0;
    int         first_v = -1;
    int         last_v = -1;
    int         uf_idx = -1;
    int         nuf = 0;
    int         saw_not_ready = 0;
    syms[0] = 2'b00; exps[0] = 50;
    syms[1] = 2'b01; exps[1] = 150;
    syms[2] = 2'b11; exps[2] = -50;
    syms[3] = 2'b10; exps[3] = -150;
    @(negedge clk);
    cos       = 8'd100;
    sin       = 8'd50;
    sym_data  = syms[0];
    sym_valid = 1'b1;
    acc       = sym_ready;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (mod_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        if (n < 16) begin
          chk($sformatf("b2b sample%0d mod_out", n), int'($signed(mod_out)), exps[n/4]);
          chk($sformatf("b2b sample%0d sym_start", n), int'(sym_start), int'(n % 4 == 0));
        end
        n++;
      end
      if (underflow) begin
        nuf++;
        uf_idx = i;
      end
      if (acc) k++;
      if (k < 4) begin
        sym_data  = syms[k];
        sym_valid = 1'b1;
      end else begin
        sym_valid = 1'b0;
      end
      acc = sym_valid && sym_ready;
      if (sym_valid && !sym_ready) saw_not_ready = 1;
    end
    chk("b2b n_valid", n, 16);
    chk("b2b contiguous_span", last_v - first_v + 1, 16);
    chk("b2b n_underflow", nuf, 1);
    chk("b2b underflow_idx", uf_idx, last_v - 1);
    chk("b2b saw_ready_low", saw_not_ready, 1);
  endtask

  // enable dropped during cycle 2 of a symbol with a second one buffered.
  task automatic enable_drop();
    int nvalid = 0;
    int nuf    = 0;
    int nbad   = 0;
    int first_idx = -1;
    @(negedge clk);
    cos       = 8'd100;
    sin       = 8'd50;
    sym_data  = 2'b00;
    sym_valid = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (mod_valid) begin
        nvalid++;
        if (int'($signed(mod_out)) != 50) nbad++;
      end
      if (underflow) nuf++;
      case (i)
        1: begin
          chk("endrop ready_while_full", int'(sym_ready), 0);
          sym_data = 2'b01;
        end
        2: chk("endrop ready_after_load", int'(sym_ready), 1);
        3: begin
          sym_valid = 1'b0;
          chk("endrop ready_second_buffered", int'(sym_ready), 0);
        end
        4: enable = 1'b0;
        default: ;
      endcase
    end
    chk("endrop first n_valid", nvalid, SYMC);
    chk("endrop first bad_samples", nbad, 0);
    chk("endrop first n_underflow", nuf, 0);
    chk("endrop idle mod_valid", int'(mod_valid), 0);
    enable = 1'b1;
    nvalid = 0;
    nuf    = 0;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      if (mod_valid) begin
        if (first_idx < 0) first_idx = j;
        nvalid++;
        chk("endrop second mod_out", int'($signed(mod_out)), 150);
      end
      if (underflow) nuf++;
    end
    chk("endrop second first_valid_idx", first_idx, 3);
    chk("endrop second n_valid", nvalid, SYMC);
    chk("endrop second n_underflow", nuf, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nvalid;
    int found;

    vecs[0] = '{2'b00,  100,   50,   50};
    vecs[1] = '{2'b01,  100,   50,  150};
    vecs[2] = '{2'b11,  100,   50,  -50};
    vecs[3] = '{2'b10,  100,   50, -150};
    vecs[4] = '{2'b11, -128,  127,  255};
    vecs[5] = '{2'b10, -128, -128, P256};
    vecs[6] = '{2'b01, -128, -128, N256};
    vecs[7] = '{2'b00, -128,  127, -255};

    reset_n   = 1'b0;
    enable    = 1'b1;
    sym_data  = 2'b00;
    sym_valid = 1'b0;
    sin       = 8'd0;
    cos       = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset mod_out", int'(mod_out), 0);
    chk("reset mod_valid", int'(mod_valid), 0);
    chk("reset sym_start", int'(sym_start), 0);
    chk("reset underflow", int'(underflow), 0);
    chk("reset sym_ready", int'(sym_ready), 1);
    reset_n = 1'b1;
    @(negedge clk);

    // Table-driven single symbols
    for (int v = 0; v < 8; v++) begin
      run_symbol(vecs[v].sym, vecs[v].c, vecs[v].s, vecs[v].exp,
                 $sformatf("vec%0d", v));
    end

    back_to_back();
    repeat (4) @(negedge clk);

    enable_drop();
    repeat (4) @(negedge clk);

    // sym_valid while disabled: nothing is accepted
    enable    = 1'b0;
    sym_data  = 2'b11;
    sym_valid = 1'b1;
    nvalid    = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("disabled sym_ready c%0d", i), int'(sym_ready), 0);
      if (mod_valid || mod_out != 10'd0) nvalid++;
    end
    chk("disabled outputs_active", nvalid, 0);
    sym_valid = 1'b0;
    enable    = 1'b1;
    nvalid    = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mod_valid) nvalid++;
    end
    chk("disabled nothing_accepted", nvalid, 0);

    // Reset mid-symbol with a second symbol buffered
    cos       = 8'd100;
    sin       = 8'd50;
    sym_data  = 2'b00;
    sym_valid = 1'b1;
    found     = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      sym_data = 2'b01;
      if (mod_valid) found = 1;
    end
    sym_valid = 1'b0;
    chk("midreset reached_active", found, 1);
    reset_n = 1'b0;
    #1;
    chk("midreset mod_valid", int'(mod_valid), 0);
    chk("midreset mod_out", int'(mod_out), 0);
    chk("midreset sym_ready", int'(sym_ready), 1);
    chk("midreset sym_start", int'(sym_start), 0);
    @(negedge clk);
    reset_n = 1'b1;
    nvalid  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mod_valid || underflow) nvalid++;
    end
    chk("midreset discarded", nvalid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
